evt_sched_rr: RTL and testbench

- Per-channel event scheduler that sits directly upstream of the team's bitmap-to-number encoder (`encodex`).
- Accumulates single-cycle event pulses from NCH channels into a sticky pending bitmap.
- Drives a round-robin-masked bitmap to the encoder, takes back the encoded index and nonzero flag, and issues one registered grant per handshake.
- Used for servicing per-tributary (E1) alarms/requests in channel order with fairness.

---
 rtl/evt_sched_rr.sv | 76 +++++++
 tb/tb_evt_sched_rr.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/evt_sched_rr.sv
// rtl/evt_sched_rr.sv - round-robin event scheduler feeding an external highest-bit encoder
// Sticky per-channel pending bits, masked bitmap to the encoder, one registered grant per handshake.
module evt_sched_rr #(
   parameter int NCH  = 32,
   parameter int IDXW = 5,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic [NCH-1:0]  evt_in,
   output logic [NCH-1:0]  bmp_out,
   input  logic [IDXW-1:0] idx_in,
   input  logic            nonz_in,
   output logic            gnt_vld,
   output logic [IDXW-1:0] gnt_idx,
   input  logic            gnt_rdy,
   output logic [NCH-1:0]  pend_out,
   output logic [CNTW-1:0] drop_cnt,
   input  logic            drop_clr
);

   logic [NCH-1:0]  pend;
   logic [IDXW-1:0] last;
   logic [NCH-1:0]  lowmask;
   logic [NCH-1:0]  low_pend;
   logic [NCH-1:0]  clrvec;
   logic            idx_ok;
   logic            ld;
   logic            drop_hit;

   // Channels strictly below the last grant go first; the encoder picks the highest.
   always_comb begin
      lowmask = '0;
      for (int i = 0; i < NCH; i++) begin
         lowmask[i] = (i < int'(last));
      end
   end

   assign low_pend = pend & lowmask;
   assign bmp_out  = (|low_pend) ? low_pend : pend;
   assign pend_out = pend;

   assign idx_ok   = (int'(idx_in) < NCH);
   assign ld       = enable & nonz_in & idx_ok & (~gnt_vld | gnt_rdy);
   assign clrvec   = ld ? ({{(NCH-1){1'b0}}, 1'b1} << idx_in) : '0;
   assign drop_hit = |(evt_in & pend & ~clrvec);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend     <= '0;
         gnt_vld  <= 1'b0;
         gnt_idx  <= '0;
         last     <= IDXW'(NCH - 1);
         drop_cnt <= '0;
      end else begin
         // A new event on the channel being granted re-arms it (set wins).
         pend <= (pend & ~clrvec) | evt_in;

         if (ld) begin
            gnt_vld <= 1'b1;
            gnt_idx <= idx_in;
            last    <= idx_in;
         end else if (gnt_vld && gnt_rdy) begin
            gnt_vld <= 1'b0;
         end

         if (drop_clr) begin
            drop_cnt <= '0;
         end else if (drop_hit && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_evt_sched_rr.sv
// tb/tb_evt_sched_rr.sv - directed self-checking bench for evt_sched_rr
// Includes a behavioural highest-set-bit encoder closing the loop on bmp_out.
module tb_evt_sched_rr;

   localparam int NCH  = 32;
   localparam int IDXW = 5;
   localparam int CNTW = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [NCH-1:0]  evt_in;
   logic [NCH-1:0]  bmp_out;
   logic [IDXW-1:0] idx_in;
   logic            nonz_in;
   logic            gnt_vld;
   logic [IDXW-1:0] gnt_idx;
   logic            gnt_rdy;
   logic [NCH-1:0]  pend_out;
   logic [CNTW-1:0] drop_cnt;
   logic            drop_clr;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   evt_sched_rr #(.NCH(NCH), .IDXW(IDXW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .evt_in(evt_in),
      .bmp_out(bmp_out), .idx_in(idx_in), .nonz_in(nonz_in),
      .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .gnt_rdy(gnt_rdy),
      .pend_out(pend_out), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
   );

   always_comb begin
      idx_in = '0;
      for (int i = 0; i < NCH; i++) begin
         if (bmp_out[i]) idx_in = IDXW'(i);
      end
      nonz_in = |bmp_out;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b1; evt_in = '0; gnt_rdy = 1'b1; drop_clr = 1'b0;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (gnt_vld !== 1'b0) $display("FAIL reset_vld got %0b want 0", gnt_vld); else passes++;
      checks++; if (gnt_idx !== 5'd0) $display("FAIL reset_idx got %0d want 0", gnt_idx); else passes++;
      checks++; if (pend_out !== 32'h0) $display("FAIL reset_pend got %h want 0", pend_out); else passes++;
      checks++; if (bmp_out !== 32'h0) $display("FAIL reset_bmp got %h want 0", bmp_out); else passes++;
      checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_cnt); else passes++;
   endtask

   task automatic test_single();
      do_reset();
      evt_in = 32'h20;
      tick();
      evt_in = '0;
      checks++; if (pend_out !== 32'h20) $display("FAIL single_pend got %h want 20", pend_out); else passes++;
      checks++; if (gnt_vld !== 1'b0) $display("FAIL single_vld_early got %0b want 0", gnt_vld); else passes++;
      tick();
      checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 5'd5) $display("FAIL single_gnt got vld=%0b idx=%0d want 1/5", gnt_vld, gnt_idx); else passes++;
      checks++; if (pend_out !== 32'h0) $display("FAIL single_pend_clr got %h want 0", pend_out); else passes++;
      tick();
      checks++; if (gnt_vld !== 1'b0) $display("FAIL single_vld_drop got %0b want 0", gnt_vld); else passes++;
   endtask

   task automatic test_back_to_back();
      logic [IDXW-1:0] exp_seq [3];
      exp_seq[0] = 5'd8; exp_seq[1] = 5'd4; exp_seq[2] = 5'd0;
      do_reset();
      evt_in = 32'h111;
      tick();
      evt_in = '0;
      checks++; if (pend_out !== 32'h111) $display("FAIL b2b_pend got %h want 111", pend_out); else passes++;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (gnt_vld !== 1'b1 || gnt_idx !== exp_seq[k])
            $display("FAIL b2b_gnt%0d got vld=%0b idx=%0d want 1/%0d", k, gnt_vld, gnt_idx, exp_seq[k]);
         else passes++;
      end
      tick();
      checks++; if (gnt_vld !== 1'b0) $display("FAIL b2b_idle got %0b want 0", gnt_vld); else passes++;
   endtask

   task automatic test_round_robin();
      logic [IDXW-1:0] exp_seq [4];
      exp_seq[0] = 5'd2; exp_seq[1] = 5'd9; exp_seq[2] = 5'd2; exp_seq[3] = 5'd9;
      do_reset();
      evt_in = 32'h10;
      tick();
      evt_in = 32'h204;
      tick();
      checks++; if (gnt_idx !== 5'd4 || pend_out !== 32'h204) $display("FAIL rr_setup got idx=%0d pend=%h want 4/204", gnt_idx, pend_out); else passes++;
      for (int k = 0; k < 4; k++) begin
         evt_in = 32'h1 << exp_seq[k];
         tick();
         checks++;
         if (gnt_vld !== 1'b1 || gnt_idx !== exp_seq[k])
            $display("FAIL rr_gnt%0d got vld=%0b idx=%0d want 1/%0d", k, gnt_vld, gnt_idx, exp_seq[k]);
         else passes++;
      end
      evt_in = '0;
      checks++; if (drop_cnt !== 8'd0) $display("FAIL rr_drop got %0d want 0", drop_cnt); else passes++;
   endtask

   task automatic test_stall();
      do_reset();
      gnt_rdy = 1'b0;
      evt_in = 32'hA;
      tick();
      evt_in = '0;
      tick();
      checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 5'd3) $display("FAIL stall_first got vld=%0b idx=%0d want 1/3", gnt_vld, gnt_idx); else passes++;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (gnt_vld !== 1'b1 || gnt_idx !== 5'd3 || pend_out !== 32'h2)
            $display("FAIL stall_hold%0d got vld=%0b idx=%0d pend=%h want 1/3/2", k, gnt_vld, gnt_idx, pend_out);
         else passes++;
      end
      gnt_rdy = 1'b1;
      tick();
      checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 5'd1 || pend_out !== 32'h0) $display("FAIL stall_next got vld=%0b idx=%0d pend=%h want 1/1/0", gnt_vld, gnt_idx, pend_out); else passes++;
      tick();
      checks++; if (gnt_vld !== 1'b0) $display("FAIL stall_idle got %0b want 0", gnt_vld); else passes++;
   endtask

   task automatic test_set_wins();
      do_reset();
      evt_in = 32'h80;
      tick();
      tick();
      evt_in = '0;
      checks++; if (gnt_idx !== 5'd7 || pend_out !== 32'h80) $display("FAIL setwins_first got idx=%0d pend=%h want 7/80", gnt_idx, pend_out); else passes++;
      checks++; if (drop_cnt !== 8'd0) $display("FAIL setwins_drop got %0d want 0", drop_cnt); else passes++;
      tick();
      checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 5'd7 || pend_out !== 32'h0) $display("FAIL setwins_second got vld=%0b idx=%0d pend=%h want 1/7/0", gnt_vld, gnt_idx, pend_out); else passes++;
      enable = 1'b0;
      evt_in = 32'h80;
      tick();
      checks++; if (gnt_vld !== 1'b0 || pend_out !== 32'h80) $display("FAIL disable got vld=%0b pend=%h want 0/80", gnt_vld, pend_out); else passes++;
      tick();
      evt_in = '0;
      checks++; if (drop_cnt !== 8'd1) $display("FAIL drop_one got %0d want 1", drop_cnt); else passes++;
   endtask

   task automatic test_drop_saturate();
      evt_in = 32'h80;
      for (int k = 0; k < 300; k++) tick();
      checks++; if (drop_cnt !== 8'd255) $display("FAIL drop_sat got %0d want 255", drop_cnt); else passes++;
      drop_clr = 1'b1;
      tick();
      drop_clr = 1'b0;
      evt_in = '0;
      checks++; if (drop_cnt !== 8'd0) $display("FAIL drop_clr got %0d want 0", drop_cnt); else passes++;
      tick();
      checks++; if (drop_cnt !== 8'd0) $display("FAIL drop_hold got %0d want 0", drop_cnt); else passes++;
   endtask

   task automatic test_reset_mid_grant();
      gnt_rdy = 1'b0;
      enable = 1'b1;
      tick();
      checks++; if (gnt_vld !== 1'b1 || gnt_idx !== 5'd7) $display("FAIL midrst_setup got vld=%0b idx=%0d want 1/7", gnt_vld, gnt_idx); else passes++;
      evt_in = 32'h3;
      tick();
      rst = 1'b1;
      #1;
      checks++; if (gnt_vld !== 1'b0 || pend_out !== 32'h0 || bmp_out !== 32'h0) $display("FAIL midrst got vld=%0b pend=%h bmp=%h want 0/0/0", gnt_vld, pend_out, bmp_out); else passes++;
      evt_in = '0;
      tick();
      rst = 1'b0;
      gnt_rdy = 1'b1;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; evt_in = '0; gnt_rdy = 1'b0; drop_clr = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_round_robin();
      test_stall();
      test_set_wins();
      test_drop_saturate();
      test_reset_mid_grant();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
